pam4_rx_lane_decoder: RTL and testbench

Parametrised multi-lane PAM4 receive decoder for the SERDES RX path. Each accepted input word holds one voltage sample per lane. The block slices each sample against three programmable thresholds, optionally Gray-decodes the resulting level, buffers decoded words in a FIFO and serialises them onto a single valid/ready bit stream. It also keeps sticky overflow, drop and near-threshold (margin) statistics for the bit-error measurement path.

---
 rtl/pam4_rx_lane_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_pam4_rx_lane_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pam4_rx_lane_decoder.sv
// Multi-lane PAM4 receive decoder: threshold slicer, optional Gray decode,
// decoded-word FIFO, single-bit valid/ready serialiser and sticky link statistics.
module pam4_rx_lane_decoder #(
  parameter int LANES      = 1,
  parameter int VWIDTH     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int GRAY_EN    = 1,
  parameter int GUARD      = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [LANES*VWIDTH-1:0]   voltage_level_in,
  input  logic                      voltage_level_in_valid,
  input  logic [VWIDTH-1:0]         th_low,
  input  logic [VWIDTH-1:0]         th_mid,
  input  logic [VWIDTH-1:0]         th_high,
  input  logic                      clear_stats,
  output logic [2*LANES-1:0]        symbol_out,
  output logic                      symbol_out_valid,
  output logic                      data_out,
  output logic                      data_out_valid,
  input  logic                      data_out_ready,
  output logic                      overflow,
  output logic [15:0]               drop_count,
  output logic [15:0]               margin_count
);

  localparam int WW  = 2 * LANES;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int CW  = $clog2(WW);
  localparam int VW1 = VWIDTH + 1;
  localparam logic [VWIDTH:0] GUARD_V  = VW1'(GUARD);
  localparam logic [AW:0]     DEPTH_V  = AW1'(FIFO_DEPTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WW - 1);

  typedef enum logic {S_IDLE, S_SHIFT} ser_state_e;

  function automatic logic [1:0] slice_level(input logic [VWIDTH-1:0] v,
                                             input logic [VWIDTH-1:0] tl,
                                             input logic [VWIDTH-1:0] tm,
                                             input logic [VWIDTH-1:0] th);
    if (v < tl) return 2'd0;
    if (v < tm) return 2'd1;
    if (v < th) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [1:0] level_to_bits(input logic [1:0] lvl);
    if (GRAY_EN != 0) return {lvl[1], lvl[1] ^ lvl[0]};
    return lvl;
  endfunction

  // Difference taken one bit wider so both directions are representable.
  function automatic logic near_threshold(input logic [VWIDTH-1:0] v,
                                          input logic [VWIDTH-1:0] th);
    logic signed [VWIDTH:0] diff;
    logic        [VWIDTH:0] mag;
    diff = $signed({1'b0, v}) - $signed({1'b0, th});
    mag  = diff[VWIDTH] ? $unsigned(-diff) : $unsigned(diff);
    return (mag < GUARD_V);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [WW-1:0]   lvl_d;
  logic [WW-1:0]   bits_d;
  logic            marginal_d;

  logic [WW-1:0]   sym_p1_q;
  logic [WW-1:0]   word_p1_q;
  logic            vld_p1_q;

  logic [WW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            fifo_full, fifo_empty, wr_en, rd_en, drop;

  logic            overflow_q;
  logic [15:0]     drop_q, margin_q;

  ser_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   sword_q, sword_d;
  logic            consume, last_bit, load;

  always_comb begin
    lvl_d      = '0;
    bits_d     = '0;
    marginal_d = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lvl_d[2*l +: 2]  = slice_level(voltage_level_in[l*VWIDTH +: VWIDTH],
                                     th_low, th_mid, th_high);
      bits_d[2*l +: 2] = level_to_bits(lvl_d[2*l +: 2]);
      if (near_threshold(voltage_level_in[l*VWIDTH +: VWIDTH], th_low) ||
          near_threshold(voltage_level_in[l*VWIDTH +: VWIDTH], th_mid) ||
          near_threshold(voltage_level_in[l*VWIDTH +: VWIDTH], th_high))
        marginal_d = 1'b1;
    end
  end

  // ---- stage p1: sliced levels and decoded word ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1_q <= 1'b0;
      sym_p1_q <= '0;
    end else begin
      vld_p1_q <= voltage_level_in_valid;
      if (voltage_level_in_valid) sym_p1_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (voltage_level_in_valid) word_p1_q <= bits_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                                    margin_q <= '0;
    else if (clear_stats)                            margin_q <= '0;
    else if (voltage_level_in_valid && marginal_d)   margin_q <= sat_inc(margin_q);
  end

  // ---- stage p2: FIFO write; a read in the same cycle frees the slot ----
  assign fifo_full  = (count_q == DEPTH_V);
  assign fifo_empty = (count_q == '0);
  assign rd_en      = load;
  assign wr_en      = vld_p1_q && (!fifo_full || rd_en);
  assign drop       = vld_p1_q && fifo_full && !rd_en;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + AW1'(1);
      2'b01:   count_d = count_q - AW1'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= word_p1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (clear_stats) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      drop_q     <= sat_inc(drop_q);
    end
  end

  // ---- serialiser: reload on the last consumed bit so words run gap-free ----
  assign consume  = (state_q == S_SHIFT) && data_out_ready;
  assign last_bit = (cnt_q == LAST_BIT);
  assign load     = !fifo_empty && ((state_q == S_IDLE) || (consume && last_bit));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sword_d = sword_q;
    if (load) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      sword_d = mem_q[rd_ptr_q];
    end else if (consume) begin
      if (last_bit) state_d = S_IDLE;
      else          cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    sword_q <= sword_d;
  end

  // Flipping bit 0 of the count walks b1 before b0 within each lane.
  assign data_out_valid   = (state_q == S_SHIFT);
  assign data_out         = data_out_valid & sword_q[cnt_q ^ CW'(1)];
  assign symbol_out       = sym_p1_q;
  assign symbol_out_valid = vld_p1_q;
  assign overflow         = overflow_q;
  assign drop_count       = drop_q;
  assign margin_count     = margin_q;

endmodule

// File: tb/tb_pam4_rx_lane_decoder.sv
// Directed self-checking bench for pam4_rx_lane_decoder (LANES=2, Gray decode on).
module tb_pam4_rx_lane_decoder;
  localparam int LANES = 2;
  localparam int VW    = 8;
  localparam logic [1:0] GRAY_LUT [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  localparam logic [7:0] LVL_SMP  [4] = '{8'h20, 8'h50, 8'h90, 8'hF0};

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [LANES*VW-1:0]   vin;
  logic                  vvalid;
  logic [VW-1:0]         th_low, th_mid, th_high;
  logic                  clr;
  logic [2*LANES-1:0]    symbol_out;
  logic                  sov;
  logic                  dout, dvalid, dready;
  logic                  overflow;
  logic [15:0]           drop_count, margin_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pam4_rx_lane_decoder #(.LANES(LANES), .VWIDTH(VW), .FIFO_DEPTH(16), .GRAY_EN(1), .GUARD(4)) dut (
    .clk(clk), .reset_n(rst_n),
    .voltage_level_in(vin), .voltage_level_in_valid(vvalid),
    .th_low(th_low), .th_mid(th_mid), .th_high(th_high),
    .clear_stats(clr),
    .symbol_out(symbol_out), .symbol_out_valid(sov),
    .data_out(dout), .data_out_valid(dvalid), .data_out_ready(dready),
    .overflow(overflow), .drop_count(drop_count), .margin_count(margin_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [1:0] l1, input logic [1:0] l0);
    vin    = {LVL_SMP[l1], LVL_SMP[l0]};
    vvalid = 1'b1;
    tick();
    vvalid = 1'b0;
  endtask

  function automatic logic [3:0] exp_bits(input logic [1:0] l1, input logic [1:0] l0);
    return {GRAY_LUT[l0], GRAY_LUT[l1]};
  endfunction

  task automatic collect(input int n, input int budget, output logic [127:0] bits, output int got);
    bits = '0;
    got  = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (dvalid && dready) begin
        bits = {bits[126:0], dout};
        got++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vvalid = 1'b0; vin = '0; clr = 1'b0; dready = 1'b1;
    th_low = 8'd64; th_mid = 8'd128; th_high = 8'd192;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tests++; if (symbol_out !== 4'h0) begin fails++; $display("FAIL reset_symbol_out got=%h exp=0", symbol_out); end
    tests++; if (sov !== 1'b0) begin fails++; $display("FAIL reset_sov got=%b exp=0", sov); end
    tests++; if (dvalid !== 1'b0 || dout !== 1'b0) begin fails++; $display("FAIL reset_dout got v=%b d=%b exp 0/0", dvalid, dout); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    tests++; if (margin_count !== 16'd0) begin fails++; $display("FAIL reset_margin got=%0d exp=0", margin_count); end
  endtask

  task automatic test_basic_decode();
    logic [127:0] bits;
    int got;
    dready = 1'b1;
    vin = {8'hF0, 8'h20}; vvalid = 1'b1;
    tick();
    vvalid = 1'b0;
    tests++; if (symbol_out !== 4'hC) begin fails++; $display("FAIL basic_symbol got=%h exp=c", symbol_out); end
    tests++; if (sov !== 1'b1) begin fails++; $display("FAIL basic_sov got=%b exp=1", sov); end
    tick();
    tests++; if (sov !== 1'b0) begin fails++; $display("FAIL basic_sov_idle got=%b exp=0", sov); end
    tests++; if (dvalid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got=%b exp=0 at N+2", dvalid); end
    tick();
    tests++; if (dvalid !== 1'b1) begin fails++; $display("FAIL basic_latency got=%b exp=1 at N+3", dvalid); end
    collect(4, 10, bits, got);
    tests++; if (got !== 4 || bits[3:0] !== 4'b0010) begin fails++; $display("FAIL basic_bits got=%b (%0d bits) exp=0010", bits[3:0], got); end
    drive_word(2'd2, 2'd1);
    collect(4, 12, bits, got);
    tests++; if (got !== 4 || bits[3:0] !== 4'b0111) begin fails++; $display("FAIL basic_bits_l12 got=%b (%0d bits) exp=0111", bits[3:0], got); end
  endtask

  task automatic test_threshold_edges();
    logic [7:0] smp [6];
    logic [1:0] lvl [6];
    smp = '{8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192};
    lvl = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    dready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vin = {8'h20, smp[i]}; vvalid = 1'b1;
      tick();
      tests++;
      if (symbol_out !== {2'b00, lvl[i]}) begin
        fails++; $display("FAIL thresh_%0d got=%h exp=%h", smp[i], symbol_out, {2'b00, lvl[i]});
      end
    end
    vvalid = 1'b0;
    repeat (40) tick();
    tests++; if (margin_count !== 16'd6) begin fails++; $display("FAIL thresh_margin got=%0d exp=6", margin_count); end
    tests++; if (dvalid !== 1'b0) begin fails++; $display("FAIL thresh_drain got=%b exp=0", dvalid); end
  endtask

  task automatic test_backpressure();
    logic [127:0] bits;
    int got;
    dready = 1'b0;
    for (int i = 0; i < 20; i++) drive_word(2'((i / 4) % 4), 2'(i % 4));
    tick();
    tick();
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL bp_overflow got=%b exp=1", overflow); end
    tests++; if (drop_count !== 16'd3) begin fails++; $display("FAIL bp_drop got=%0d exp=3", drop_count); end
    tests++; if (dvalid !== 1'b1 || dout !== 1'b0) begin fails++; $display("FAIL bp_hold got v=%b d=%b exp 1/0", dvalid, dout); end
    dready = 1'b1;
    collect(68, 200, bits, got);
    tests++; if (got !== 68) begin fails++; $display("FAIL bp_count got=%0d exp=68", got); end
    for (int k = 0; k < 17; k++) begin
      tests++;
      if (bits[(16 - k) * 4 +: 4] !== exp_bits(2'((k / 4) % 4), 2'(k % 4))) begin
        fails++; $display("FAIL bp_word%0d got=%b exp=%b", k, bits[(16 - k) * 4 +: 4], exp_bits(2'((k / 4) % 4), 2'(k % 4)));
      end
    end
    repeat (4) tick();
    tests++; if (dvalid !== 1'b0) begin fails++; $display("FAIL bp_extra got=%b exp=0", dvalid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    int run;
    int waitc;
    dready = 1'b1;
    drive_word(2'd1, 2'd2);
    drive_word(2'd3, 2'd0);
    waitc = 0;
    while (!dvalid && waitc < 10) begin tick(); waitc++; end
    run = 0; seq = '0;
    while (dvalid && run < 20) begin
      seq = {seq[6:0], dout};
      run++;
      tick();
    end
    tests++; if (run !== 8) begin fails++; $display("FAIL b2b_run got=%0d exp=8", run); end
    tests++; if (seq !== 8'b1101_0010) begin fails++; $display("FAIL b2b_bits got=%b exp=11010010", seq); end
  endtask

  task automatic test_ready_hold();
    logic [127:0] bits;
    int got;
    int waitc;
    dready = 1'b0;
    drive_word(2'd0, 2'd2);
    waitc = 0;
    while (!dvalid && waitc < 10) begin tick(); waitc++; end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (dvalid !== 1'b1 || dout !== 1'b1) begin fails++; $display("FAIL hold_%0d got v=%b d=%b exp 1/1", i, dvalid, dout); end
      tick();
    end
    dready = 1'b1;
    collect(4, 10, bits, got);
    tests++; if (got !== 4 || bits[3:0] !== 4'b1100) begin fails++; $display("FAIL hold_bits got=%b (%0d bits) exp=1100", bits[3:0], got); end
  endtask

  task automatic test_margin();
    logic [7:0] smp [3];
    logic [15:0] expc [3];
    smp  = '{8'd125, 8'd124, 8'd131};
    expc = '{16'd1, 16'd1, 16'd2};
    dready = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++; if (margin_count !== 16'd0) begin fails++; $display("FAIL clr_margin got=%0d exp=0", margin_count); end
    tests++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin fails++; $display("FAIL clr_drop got ovf=%b drop=%0d exp 0/0", overflow, drop_count); end
    for (int i = 0; i < 3; i++) begin
      vin = {8'h20, smp[i]}; vvalid = 1'b1;
      tick();
      tests++;
      if (margin_count !== expc[i]) begin fails++; $display("FAIL margin_%0d got=%0d exp=%0d", smp[i], margin_count, expc[i]); end
    end
    vin = {8'h20, 8'd125}; vvalid = 1'b1; clr = 1'b1;
    tick();
    vvalid = 1'b0; clr = 1'b0;
    tests++; if (margin_count !== 16'd0) begin fails++; $display("FAIL margin_clr_prio got=%0d exp=0", margin_count); end
    repeat (30) tick();
  endtask

  task automatic test_mid_reset();
    logic [127:0] bits;
    int got;
    int waitc;
    int stale;
    dready = 1'b1;
    vin = {8'h20, 8'd63}; vvalid = 1'b1;
    tick();
    drive_word(2'd3, 2'd3);
    drive_word(2'd2, 2'd2);
    drive_word(2'd1, 2'd1);
    waitc = 0;
    while (!dvalid && waitc < 10) begin tick(); waitc++; end
    tick();
    tests++; if (margin_count !== 16'd1) begin fails++; $display("FAIL mrst_pre_margin got=%0d exp=1", margin_count); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++; if (dvalid !== 1'b0 || dout !== 1'b0) begin fails++; $display("FAIL mrst_dout got v=%b d=%b exp 0/0", dvalid, dout); end
    tests++; if (sov !== 1'b0 || symbol_out !== 4'h0) begin fails++; $display("FAIL mrst_symbol got v=%b s=%h exp 0/0", sov, symbol_out); end
    tests++; if (margin_count !== 16'd0) begin fails++; $display("FAIL mrst_margin got=%0d exp=0", margin_count); end
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      if (dvalid) stale++;
      tick();
    end
    tests++; if (stale !== 0) begin fails++; $display("FAIL mrst_stale got=%0d valid cycles exp=0", stale); end
    drive_word(2'd0, 2'd1);
    collect(4, 12, bits, got);
    tests++; if (got !== 4 || bits[3:0] !== 4'b0100) begin fails++; $display("FAIL mrst_after got=%b (%0d bits) exp=0100", bits[3:0], got); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_decode();
    test_threshold_edges();
    test_backpressure();
    test_back_to_back();
    test_ready_hold();
    test_margin();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
